// File: rtl/ttl_pkg.sv
// Shared types for the timestamp-driven TTL sequencer: event record, pop
// classification and the masked-merge helper. Widths are capped at 64 bits.
package ttl_pkg;

   localparam int TTL_N_CH_MAX     = 64;
   localparam int TTL_TS_WIDTH_MAX = 64;

   // Narrower instances zero-extend their fields into this record.
   typedef struct packed {
      logic [TTL_TS_WIDTH_MAX-1:0] time_stamp;
      logic [TTL_N_CH_MAX-1:0]     mask;
      logic [TTL_N_CH_MAX-1:0]     value;
   } ttl_event_t;

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_FIRE,
      ST_LATE
   } pop_state_e;

   function automatic logic [TTL_N_CH_MAX-1:0] ttl_merge(
      input logic [TTL_N_CH_MAX-1:0] old_levels,
      input logic [TTL_N_CH_MAX-1:0] mask,
      input logic [TTL_N_CH_MAX-1:0] value
   );
      return (old_levels & ~mask) | (value & mask);
   endfunction

endpackage

// File: rtl/ttl_event_fifo.sv
// First-word-fall-through event FIFO with extra-MSB pointers, flush and level.
// The head word is read straight from the array so it is visible one cycle after its write.
module ttl_event_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 64,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic          empty,
   output logic          full,
   output logic [LW-1:0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic         wr_fire;
   logic         rd_fire;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level   = LW'(wr_ptr_q - rd_ptr_q);
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   // A write coinciding with flush is dropped outright.
   assign wr_fire = wr_en && !full && !flush;
   assign rd_fire = rd_en && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/ttl_timed_sequencer.sv
// Timestamp-driven TTL sequencer: applies buffered events when their time matches
// the free-running counter. Define TTL_LATE_DROP_EN to discard late events instead of applying them.
module ttl_timed_sequencer
   import ttl_pkg::*;
#(
   parameter int              N_CH       = 32,
   parameter int              TS_WIDTH   = 48,
   parameter int              DEPTH      = 64,
   parameter logic [N_CH-1:0] INIT_VALUE = '0
) (
   input  logic                     s_axi_aclk,
   input  logic                     s_axi_aresetn,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [TS_WIDTH-1:0]      cmd_time,
   input  logic [N_CH-1:0]          cmd_mask,
   input  logic [N_CH-1:0]          cmd_value,
   input  logic                     run,
   input  logic                     time_clear,
   input  logic                     flush,
   input  logic                     late_clear,
   output logic [N_CH-1:0]          ttl_out,
   output logic [TS_WIDTH-1:0]      time_now,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     late_flag,
   output logic                     busy
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int W  = TS_WIDTH + 2 * N_CH;

   logic [TS_WIDTH-1:0] time_q, time_d;
   logic [N_CH-1:0]     ttl_q, ttl_d;
   logic                late_q, late_d;

   logic [W-1:0]        fifo_rd_data;
   logic                fifo_empty;
   logic                fifo_full;
   logic [LW-1:0]       fifo_level_w;
   ttl_event_t          head;
   pop_state_e          pop_state;
   logic                pop;
   logic [N_CH-1:0]     ttl_merged;

   ttl_event_fifo #(
      .W     (W),
      .DEPTH (DEPTH),
      .LW    (LW)
   ) u_fifo (
      .clk     (s_axi_aclk),
      .rst_n   (s_axi_aresetn),
      .flush   (flush),
      .wr_en   (cmd_valid),
      .wr_data ({cmd_time, cmd_mask, cmd_value}),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .level   (fifo_level_w)
   );

   always_comb begin
      head            = '0;
      head.time_stamp = TTL_TS_WIDTH_MAX'(fifo_rd_data[W-1 -: TS_WIDTH]);
      head.mask       = TTL_N_CH_MAX'(fifo_rd_data[2*N_CH-1 -: N_CH]);
      head.value      = TTL_N_CH_MAX'(fifo_rd_data[N_CH-1:0]);
   end

   // Plain unsigned compare; timestamps are expected monotonic within one counter epoch.
   always_comb begin
      pop_state = ST_WAIT;
      if (run && !fifo_empty) begin
         if (head.time_stamp == TTL_TS_WIDTH_MAX'(time_q)) begin
            pop_state = ST_FIRE;
         end else if (head.time_stamp < TTL_TS_WIDTH_MAX'(time_q)) begin
            pop_state = ST_LATE;
         end
      end
   end

   assign pop        = (pop_state != ST_WAIT);
   assign ttl_merged = N_CH'(ttl_merge(TTL_N_CH_MAX'(ttl_q), head.mask, head.value));

   always_comb begin
      ttl_d  = ttl_q;
      late_d = late_q;
      if (late_clear) late_d = 1'b0;
      case (pop_state)
         ST_FIRE: ttl_d = ttl_merged;
         ST_LATE: begin
            late_d = 1'b1;
`ifdef TTL_LATE_DROP_EN
            ttl_d  = ttl_q;
`else
            ttl_d  = ttl_merged;
`endif
         end
         default: ttl_d = ttl_q;
      endcase
   end

   always_comb begin
      time_d = time_q;
      if (time_clear) begin
         time_d = '0;
      end else if (run) begin
         time_d = time_q + TS_WIDTH'(1);
      end
   end

   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         time_q <= '0;
         ttl_q  <= INIT_VALUE;
         late_q <= 1'b0;
      end else begin
         time_q <= time_d;
         ttl_q  <= ttl_d;
         late_q <= late_d;
      end
   end

   assign cmd_ready  = !fifo_full;
   assign busy       = (fifo_level_w != '0);
   assign fifo_level = fifo_level_w;
   assign ttl_out    = ttl_q;
   assign time_now   = time_q;
   assign late_flag  = late_q;

endmodule

// File: tb/tb_ttl_timed_sequencer.sv
// Directed bench for ttl_timed_sequencer; expected TTL levels are queued with the
// time_now value at which they must appear and checked as the counter reaches them.
module tb_ttl_timed_sequencer;

   localparam int N   = 8;
   localparam int TSW = 16;
   localparam int D   = 8;

   logic           clk = 1'b0;
   logic           aresetn = 1'b0;
   logic           cmd_valid = 1'b0;
   logic           cmd_ready;
   logic [TSW-1:0] cmd_time = '0;
   logic [N-1:0]   cmd_mask = '0;
   logic [N-1:0]   cmd_value = '0;
   logic           run = 1'b0;
   logic           time_clear = 1'b0;
   logic           flush = 1'b0;
   logic           late_clear = 1'b0;
   logic [N-1:0]   ttl_out;
   logic [TSW-1:0] time_now;
   logic [3:0]     fifo_level;
   logic           late_flag;
   logic           busy;

   typedef struct {
      logic [TSW-1:0] t;
      logic [N-1:0]   v;
   } exp_t;

   exp_t         sb[$];
   logic [N-1:0] exp_model;
   logic [N-1:0] exp_cur;
   int           n_vec = 0;
   int           n_err = 0;

   ttl_timed_sequencer #(
      .N_CH       (N),
      .TS_WIDTH   (TSW),
      .DEPTH      (D),
      .INIT_VALUE (8'hA5)
   ) dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (aresetn),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_time      (cmd_time),
      .cmd_mask      (cmd_mask),
      .cmd_value     (cmd_value),
      .run           (run),
      .time_clear    (time_clear),
      .flush         (flush),
      .late_clear    (late_clear),
      .ttl_out       (ttl_out),
      .time_now      (time_now),
      .fifo_level    (fifo_level),
      .late_flag     (late_flag),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h (time_now=%0d)", tag, obs, exp, time_now);
      end
      $display("check %-12s obs=%0h exp=%0h time_now=%0d", tag, obs, exp, time_now);
   endtask

   // Queue the level expected once time_now reads t_vis.
   task automatic push_exp(input logic [TSW-1:0] t_vis, input logic [N-1:0] m, input logic [N-1:0] v);
      exp_t e;
      exp_model = (exp_model & ~m) | (v & m);
      e.t = t_vis;
      e.v = exp_model;
      sb.push_back(e);
   endtask

   task automatic wr_evt(input logic [TSW-1:0] t, input logic [N-1:0] m, input logic [N-1:0] v);
      int g;
      cmd_time  = t;
      cmd_mask  = m;
      cmd_value = v;
      cmd_valid = 1'b1;
      g = 0;
      while (!cmd_ready && g < 50) begin
         tick();
         g++;
      end
      chk("wr_ready", 64'(cmd_ready), 64'd1);
      tick();
      cmd_valid = 1'b0;
      $display("write T=%0d mask=%0h value=%0h level=%0d", t, m, v, fifo_level);
   endtask

   task automatic run_check(input int n, input bit drain);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         tick();
         if (sb.size() > 0 && time_now == sb[0].t) begin
            e = sb.pop_front();
            exp_cur = e.v;
         end
         chk("ttl_out", 64'(ttl_out), 64'(exp_cur));
      end
      if (drain) chk("sb_drain", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      exp_model = 8'hA5;
      exp_cur   = 8'hA5;

      // Reset state
      tick();
      tick();
      chk("rst_ttl", 64'(ttl_out), 64'hA5);
      chk("rst_time", 64'(time_now), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_ready", 64'(cmd_ready), 64'd1);
      chk("rst_late", 64'(late_flag), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      aresetn = 1'b1;
      tick();

      // Basic fire: clear all, then set and clear bit0
      wr_evt(16'd3, 8'hFF, 8'h00);
      push_exp(16'd4, 8'hFF, 8'h00);
      wr_evt(16'd10, 8'h01, 8'h01);
      push_exp(16'd11, 8'h01, 8'h01);
      wr_evt(16'd20, 8'h01, 8'h00);
      push_exp(16'd21, 8'h01, 8'h00);
      chk("bf_level", 64'(fifo_level), 64'd3);
      chk("bf_busy", 64'(busy), 64'd1);
      time_clear = 1'b1;
      tick();
      time_clear = 1'b0;
      chk("bf_time0", 64'(time_now), 64'd0);
      run = 1'b1;
      run_check(25, 1'b1);
      run = 1'b0;
      chk("bf_time25", 64'(time_now), 64'd25);
      chk("bf_late", 64'(late_flag), 64'd0);
      chk("bf_busy_end", 64'(busy), 64'd0);

      // Same timestamp: second event is late
      time_clear = 1'b1;
      tick();
      time_clear = 1'b0;
      wr_evt(16'd5, 8'h02, 8'hFF);
      push_exp(16'd6, 8'h02, 8'hFF);
      wr_evt(16'd5, 8'h04, 8'hFF);
`ifndef TTL_LATE_DROP_EN
      push_exp(16'd7, 8'h04, 8'hFF);
`endif
      run = 1'b1;
      run_check(9, 1'b1);
      run = 1'b0;
      chk("st_late", 64'(late_flag), 64'd1);
      chk("st_bit2", 64'(ttl_out[2]), 64'(exp_model[2]));
      late_clear = 1'b1;
      tick();
      late_clear = 1'b0;
      chk("late_clear", 64'(late_flag), 64'd0);

      // Full FIFO: DEPTH writes, then an extra one is refused
      for (int i = 0; i < D; i++) wr_evt(16'(1000 + i), 8'h00, 8'h00);
      chk("full_level", 64'(fifo_level), 64'(D));
      chk("full_ready", 64'(cmd_ready), 64'd0);
      cmd_valid = 1'b1;
      tick();
      tick();
      cmd_valid = 1'b0;
      chk("full_hold", 64'(fifo_level), 64'(D));

      // Flush, refill three, then flush together with a write
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_level", 64'(fifo_level), 64'd0);
      chk("flush_busy", 64'(busy), 64'd0);
      for (int i = 0; i < 3; i++) wr_evt(16'd2000, 8'hFF, 8'h55);
      chk("refill_level", 64'(fifo_level), 64'd3);
      flush = 1'b1;
      cmd_valid = 1'b1;
      tick();
      flush = 1'b0;
      cmd_valid = 1'b0;
      chk("fw_level", 64'(fifo_level), 64'd0);
      chk("fw_busy", 64'(busy), 64'd0);
      chk("fw_ttl", 64'(ttl_out), 64'(exp_cur));
      tick();
      chk("fw_level2", 64'(fifo_level), 64'd0);

      // Hold and late: a blocking head forces the second event late
      time_clear = 1'b1;
      tick();
      time_clear = 1'b0;
      run = 1'b1;
      run_check(5, 1'b1);
      run = 1'b0;
      chk("hl_time5", 64'(time_now), 64'd5);
      wr_evt(16'd12, 8'h20, 8'h20);
      push_exp(16'd13, 8'h20, 8'h20);
      wr_evt(16'd8, 8'h10, 8'h10);
`ifndef TTL_LATE_DROP_EN
      push_exp(16'd14, 8'h10, 8'h10);
`endif
      run_check(10, 1'b0);
      chk("hl_pause_t", 64'(time_now), 64'd5);
      chk("hl_late0", 64'(late_flag), 64'd0);
      run = 1'b1;
      run_check(10, 1'b1);
      run = 1'b0;
      chk("hl_late1", 64'(late_flag), 64'd1);
      chk("hl_ttl", 64'(ttl_out), 64'(exp_model));

      // Reset mid-run with an event pending
      wr_evt(16'd100, 8'hFF, 8'hFF);
      run = 1'b1;
      tick();
      tick();
      aresetn = 1'b0;
      tick();
      aresetn = 1'b1;
      run = 1'b0;
      chk("mr_ttl", 64'(ttl_out), 64'hA5);
      chk("mr_time", 64'(time_now), 64'd0);
      chk("mr_level", 64'(fifo_level), 64'd0);
      chk("mr_ready", 64'(cmd_ready), 64'd1);
      chk("mr_busy", 64'(busy), 64'd0);
      chk("mr_late", 64'(late_flag), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
